cmp_result_debouncer: RTL and testbench
=======================================

// Module: cmp_result_debouncer
// PURPOSE
//  Downstream consumer of the 2-bit magnitude comparator flags (A_greater/A_equal/A_less).
//  Filters the per-sample relation and commits a new stable relation only after
//  STABLE_CNT consecutive identical valid samples.
//  Flags malformed (non-one-hot) flag sets and counts committed relation changes
//  for status/debug logic.
// PARAMETERS
//  STABLE_CNT  4  consecutive identical valid samples needed to commit; legal range >= 1
//  CNT_W       8  width of chg_count
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  in_valid      in   1      comparator flags are valid this cycle
//  A_greater     in   1      comparator flag: A > B
//  A_equal       in   1      comparator flag: A == B
//  A_less        in   1      comparator flag: A < B
//  clr           in   1      synchronous clear of chg_count only
//  rel_valid     out  1      a relation has been committed since reset
//  rel_greater   out  1      committed relation is greater (registered)
//  rel_equal     out  1      committed relation is equal (registered)
//  rel_less      out  1      committed relation is less (registered)
//  change_pulse  out  1      one-cycle pulse on every commit
//  chg_count     out  CNT_W  number of commits; saturates at all-ones
//  err_onehot    out  1      one-cycle pulse: in_valid with flags not exactly one-hot
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - All outputs 0.
//   - FSM in IDLE.
//   - run counter = 0; candidate = NONE.
//  FSM states: IDLE, LESS, EQUAL, GREATER.
//   - rel_* decode the state one-hot; all rel_* are 0 in IDLE.
//   - rel_valid = (state != IDLE).
//   - The FSM never returns to IDLE except via reset.
//  Sample handling (edge with in_valid=1):
//   - Malformed flags (zero or >=2 flags set):
//     - err_onehot = 1 in the next cycle.
//     - Sample discarded; run = 0; candidate = NONE; state unchanged.
//   - Well-formed flags equal to candidate: run = min(run+1, STABLE_CNT).
//   - Well-formed flags differing from candidate: candidate = flags; run = 1.
//   - Commit condition: the updated run == STABLE_CNT and candidate != state.
//     - state <= candidate on that same edge.
//     - change_pulse = 1 for exactly that cycle.
//     - chg_count += 1, saturating.
//   - Latency: outputs reflect the new relation immediately after the edge that
//     accepts the STABLE_CNT-th sample.
//     - STABLE_CNT=1 gives a single-edge update.
//   - A run equal to the current state produces no commit and no pulse.
//  in_valid=0: candidate, run and state hold; gaps do not break a run; no pulses.
//  Run counter is sized $clog2(STABLE_CNT+1) bits; it never wraps.
//  The first commit out of IDLE counts as a change: pulse asserts and chg_count increments.
//  clr=1: chg_count <= 0 on the edge.
//   - clr has priority over a same-edge commit: count ends at 0.
//   - A same-edge commit still updates state and asserts change_pulse.
//  Reset mid-run or mid-commit: everything returns to reset values; the partial run is lost.
// TESTING (STABLE_CNT=4, CNT_W=8 unless noted)
//  1. Reset, then 4 valid EQUAL samples on consecutive cycles
//     -> rel_equal=1, rel_valid=1 after the 4th edge; change_pulse for 1 cycle; chg_count=1.
//  2. From EQUAL, apply GREATER x3, LESS x1, GREATER x4
//     -> one commit, to GREATER, after the last sample; chg_count=2.
//  3. GREATER x2, in_valid=0 for 5 cycles, GREATER x2
//     -> commit on the 4th valid sample; gaps ignored.
//  4. Flags 3'b110 (or 3'b000) with in_valid mid-run
//     -> err_onehot pulses 1 cycle; run restarts; the next 4 good samples are needed to commit.
//  5. clr asserted on the commit edge
//     -> state updates, change_pulse=1, chg_count=0.
//     CNT_W=2, 5 commits -> chg_count stays 3.
//  6. rst_n dropped asynchronously mid-run (between edges)
//     -> all outputs 0 immediately.
//     STABLE_CNT=1: each valid change commits on its own edge.

Source files
------------

// File: rtl/cmp_result_debouncer.sv
// Debounces one-hot magnitude-comparator flags into a committed relation,
// flags malformed flag sets and counts committed relation changes.
module cmp_result_debouncer #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             A_greater,
    input  logic             A_equal,
    input  logic             A_less,
    input  logic             clr,
    output logic             rel_valid,
    output logic             rel_greater,
    output logic             rel_equal,
    output logic             rel_less,
    output logic             change_pulse,
    output logic [CNT_W-1:0] chg_count,
    output logic             err_onehot
);

    localparam int unsigned      RUN_W   = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);

    // The candidate register reuses this type; IDLE there means "no candidate".
    typedef enum logic [1:0] {IDLE, LESS, EQUAL, GREATER} state_e;

    state_e           state, state_nxt;
    state_e           cand, cand_nxt;
    state_e           sample_rel;
    logic [RUN_W-1:0] run, run_nxt;
    logic             well_formed;
    logic             commit;
    logic             err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= IDLE;
            run   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            run   <= run_nxt;
        end
    end

    always_comb begin
        well_formed = 1'b1;
        sample_rel  = IDLE;
        case ({A_greater, A_equal, A_less})
            3'b100:  sample_rel = GREATER;
            3'b010:  sample_rel = EQUAL;
            3'b001:  sample_rel = LESS;
            default: well_formed = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        run_nxt   = run;
        commit    = 1'b0;
        err_nxt   = 1'b0;
        if (in_valid) begin
            if (!well_formed) begin
                err_nxt  = 1'b1;
                cand_nxt = IDLE;
                run_nxt  = '0;
            end else begin
                if (sample_rel == cand) begin
                    if (run != RUN_MAX)
                        run_nxt = run + 1'b1;
                end else begin
                    cand_nxt = sample_rel;
                    run_nxt  = RUN_W'(1);
                end
                if (run_nxt == RUN_MAX && cand_nxt != state) begin
                    commit    = 1'b1;
                    state_nxt = cand_nxt;
                end
            end
        end
    end

    always_comb begin
        rel_valid   = (state != IDLE);
        rel_greater = (state == GREATER);
        rel_equal   = (state == EQUAL);
        rel_less    = (state == LESS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_pulse <= 1'b0;
            err_onehot   <= 1'b0;
            chg_count    <= '0;
        end else begin
            change_pulse <= commit;
            err_onehot   <= err_nxt;
            // clr wins over a same-edge commit; the count simply ends at zero.
            if (clr)
                chg_count <= '0;
            else if (commit && chg_count != '1)
                chg_count <= chg_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmp_result_debouncer.sv
// Scoreboard bench: two instances (4/8 and 1/2), expected events queued by the
// stimulus thread and consumed by a monitor whenever a pulse output fires.
module tb_cmp_result_debouncer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v0 = 0, g0 = 0, e0 = 0, l0 = 0, clr0 = 0;
    logic rv0, rg0, re0, rl0, cp0, err0;
    logic [7:0] cnt0;

    logic v1 = 0, g1 = 0, e1 = 0, l1 = 0, clr1 = 0;
    logic rv1, rg1, re1, rl1, cp1, err1;
    logic [1:0] cnt1;

    cmp_result_debouncer #(.STABLE_CNT(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .A_greater(g0), .A_equal(e0),
        .A_less(l0), .clr(clr0), .rel_valid(rv0), .rel_greater(rg0),
        .rel_equal(re0), .rel_less(rl0), .change_pulse(cp0), .chg_count(cnt0),
        .err_onehot(err0));

    cmp_result_debouncer #(.STABLE_CNT(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .A_greater(g1), .A_equal(e1),
        .A_less(l1), .clr(clr1), .rel_valid(rv1), .rel_greater(rg1),
        .rel_equal(re1), .rel_less(rl1), .change_pulse(cp1), .chg_count(cnt1),
        .err_onehot(err1));

    typedef struct {
        string       name;
        logic [13:0] v;   // {err, pulse, g, e, l, rel_valid, count[7:0]}
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    localparam logic [2:0] G = 3'b100, E = 3'b010, L = 3'b001;

    task automatic push(input int dut, input string n, input logic err, input logic pulse,
                        input logic [2:0] rel, input logic rv, input logic [7:0] cnt);
        exp_t x;
        x.name = n;
        x.v = {err, pulse, rel, rv, cnt};
        if (dut == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    task automatic s0(input logic [2:0] f, input logic c);
        {g0, e0, l0} = f; v0 = 1'b1; clr0 = c;
        @(posedge clk); #1;
        v0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic s1(input logic [2:0] f);
        {g1, e1, l1} = f; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every pulse on either instance must match the head of its queue.
    initial begin
        logic [13:0] a;
        exp_t x;
        forever begin
            @(negedge clk);
            a = {err0, cp0, rg0, re0, rl0, rv0, cnt0};
            if (a[13] | a[12]) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0_unexpected_event got=%h required=no event", a);
                end else begin
                    x = q0.pop_front();
                    if (a !== x.v) begin
                        errors++;
                        $display("FAIL %s got=%h required=%h", x.name, a, x.v);
                    end
                end
            end
            a = {err1, cp1, rg1, re1, rl1, rv1, 6'b0, cnt1};
            if (a[13] | a[12]) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected_event got=%h required=no event", a);
                end else begin
                    x = q1.pop_front();
                    if (a !== x.v) begin
                        errors++;
                        $display("FAIL %s got=%h required=%h", x.name, a, x.v);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [13:0] a;
        #3;
        a = {err0, cp0, rg0, re0, rl0, rv0, cnt0};
        checks++;
        if (a !== '0) begin errors++; $display("FAIL reset_dut0 got=%h required=0", a); end
        a = {err1, cp1, rg1, re1, rl1, rv1, 6'b0, cnt1};
        checks++;
        if (a !== '0) begin errors++; $display("FAIL reset_dut1 got=%h required=0", a); end
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);

        // 1: four EQUAL samples commit out of IDLE
        repeat (3) s0(E, 0);
        push(0, "t1_commit_equal", 0, 1, E, 1, 8'd1);
        s0(E, 0);
        idle(2);

        // 2: interrupted GREATER run, then a full one
        repeat (3) s0(G, 0);
        s0(L, 0);
        repeat (3) s0(G, 0);
        push(0, "t2_commit_greater", 0, 1, G, 1, 8'd2);
        s0(G, 0);
        idle(2);

        // 3: gaps in in_valid do not break the run
        repeat (2) s0(L, 0);
        idle(5);
        s0(L, 0);
        push(0, "t3_commit_less_gaps", 0, 1, L, 1, 8'd3);
        s0(L, 0);
        idle(2);

        // 4: malformed flags restart the run; matching-state run gives nothing
        repeat (2) s0(E, 0);
        push(0, "t4_err_110", 1, 0, L, 1, 8'd3);
        s0(3'b110, 0);
        repeat (3) s0(E, 0);
        push(0, "t4_commit_equal", 0, 1, E, 1, 8'd4);
        s0(E, 0);
        s0(E, 0);
        push(0, "t4_err_000", 1, 0, E, 1, 8'd4);
        s0(3'b000, 0);
        repeat (4) s0(E, 0);
        idle(2);

        // 5: clr on the commit edge
        repeat (3) s0(G, 0);
        push(0, "t5_commit_with_clr", 0, 1, G, 1, 8'd0);
        s0(G, 1);
        idle(2);

        // 6: asynchronous reset between edges loses the partial run
        repeat (2) s0(L, 0);
        #2 rst_n = 1'b0;
        #1;
        a = {err0, cp0, rg0, re0, rl0, rv0, cnt0};
        checks++;
        if (a !== '0) begin errors++; $display("FAIL t6_async_reset got=%h required=0", a); end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) s0(L, 0);
        idle(2);
        s0(L, 0);
        push(0, "t6_commit_after_reset", 0, 1, L, 1, 8'd1);
        s0(L, 0);
        idle(2);

        // STABLE_CNT=1, CNT_W=2: single-edge commits and saturation
        push(1, "s1_commit_g", 0, 1, G, 1, 8'd1); s1(G);
        push(1, "s1_commit_e", 0, 1, E, 1, 8'd2); s1(E);
        push(1, "s1_commit_l", 0, 1, L, 1, 8'd3); s1(L);
        push(1, "s1_sat_g",    0, 1, G, 1, 8'd3); s1(G);
        push(1, "s1_sat_e",    0, 1, E, 1, 8'd3); s1(E);
        s1(E);
        push(1, "s1_err_111",  1, 0, E, 1, 8'd3); s1(3'b111);
        idle(3);

        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL dut0_missing_events got=%0d pending required=0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL dut1_missing_events got=%0d pending required=0", q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
